// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS-subset CPU.
// Steps each instruction through IF/ID/EXE/MEM/WB and drives every datapath
// write enable and mux select. All outputs are combinational from the state,
// opcode, funct and zero; write enables are forced low while Reset is low.
module multicycle_ctrl (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       RegWre,
    output logic       RegDst,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] HALT_OP  = 6'b111111;

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_AL = 4'b0010,
        S_WB_AL  = 4'b0011,
        S_EXE_BR = 4'b0100,
        S_EXE_LS = 4'b0101,
        S_MEM    = 4'b0110,
        S_WB_LD  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    state_t state_q, state_d;

    // Raw enables before the reset gate.
    logic       pc_we, ir_we, reg_we, mem_rd, mem_wr;

    // ALU controls shared by EXE_AL and WB_AL (held across both states).
    logic [2:0] al_op;
    logic       al_srcb, al_ext, al_wr_ok;
    logic [2:0] r_op;
    logic       r_valid;

    // State register; reset forces IF asynchronously.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    // R-type funct decode; an unknown funct maps to add and blocks writeback.
    always_comb begin
        r_op    = 3'b000;
        r_valid = 1'b1;
        case (funct)
            6'b100000: r_op = 3'b000;
            6'b100010: r_op = 3'b001;
            6'b100100: r_op = 3'b010;
            6'b100101: r_op = 3'b011;
            6'b101010: r_op = 3'b100;
            default:   r_valid = 1'b0;
        endcase
    end

    // ALU-class instruction controls (R-type, addi, ori).
    always_comb begin
        al_op    = 3'b000;
        al_srcb  = 1'b0;
        al_ext   = 1'b0;
        al_wr_ok = 1'b1;
        if (opcode == OP_RTYPE) begin
            al_op    = r_op;
            al_wr_ok = r_valid;
        end else if (opcode == OP_ADDI) begin
            al_srcb = 1'b1;
            al_ext  = 1'b1;
        end else if (opcode == OP_ORI) begin
            al_srcb = 1'b1;
            al_op   = 3'b011;
        end
    end

    // Next-state and output decode; every output defaults to 0.
    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        PCSrc     = 2'b00;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        RegDst    = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        ExtSel    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        DBDataSrc = 1'b0;
        case (state_q)
            S_IF: begin
                ir_we   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI, OP_ORI: state_d = S_EXE_AL;
                    OP_BEQ, OP_BNE:            state_d = S_EXE_BR;
                    OP_LW, OP_SW:              state_d = S_EXE_LS;
                    OP_J: begin
                        pc_we   = 1'b1;
                        PCSrc   = 2'b10;
                        state_d = S_IF;
                    end
                    HALT_OP: state_d = S_HALT;
                    default: begin
                        // Unknown opcode retires as a NOP.
                        pc_we   = 1'b1;
                        state_d = S_IF;
                    end
                endcase
            end
            S_EXE_AL: begin
                ALUSrcB = al_srcb;
                ExtSel  = al_ext;
                ALUOp   = al_op;
                state_d = S_WB_AL;
            end
            S_WB_AL: begin
                ALUSrcB = al_srcb;
                ExtSel  = al_ext;
                ALUOp   = al_op;
                RegDst  = (opcode == OP_RTYPE);
                reg_we  = al_wr_ok;
                pc_we   = 1'b1;
                state_d = S_IF;
            end
            S_EXE_BR: begin
                ALUOp = 3'b001;
                pc_we = 1'b1;
                if ((opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero))
                    PCSrc = 2'b01;
                state_d = S_IF;
            end
            S_EXE_LS: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                state_d = S_MEM;
            end
            S_MEM: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (opcode == OP_LW) begin
                    mem_rd  = 1'b1;
                    state_d = S_WB_LD;
                end else begin
                    mem_wr  = (opcode == OP_SW);
                    pc_we   = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB_LD: begin
                reg_we    = 1'b1;
                DBDataSrc = 1'b1;
                pc_we     = 1'b1;
                state_d   = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Reset gate keeps every write enable low during and across an abort.
    assign PCWre  = pc_we  & Reset;
    assign IRWre  = ir_we  & Reset;
    assign RegWre = reg_we & Reset;
    assign mRD    = mem_rd & Reset;
    assign mWR    = mem_wr & Reset;
    assign state  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction reference model expands each
// issued instruction into its expected per-cycle control vectors; a monitor
// compares the DUT against that queue on every falling edge.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] state;

    int vectors = 0;
    int miscompares = 0;
    logic mon_en = 1'b0;

    logic [17:0] exp_q[$];
    logic [17:0] instr_q[$];
    logic [17:0] act_vec;

    logic [5:0] fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] op_tab[8] = '{6'h00, 6'h08, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};

    multicycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
        .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
        .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .state(state)
    );

    assign act_vec = {state, PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB,
                      ALUOp, ExtSel, mRD, mWR, DBDataSrc};

    // Clock
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, %0d vectors so far", vectors);
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] pack(input logic [3:0] st, input logic pcw,
                                         input logic [1:0] pcs, input logic irw,
                                         input logic regw, input logic rdst,
                                         input logic srcb, input logic [2:0] aop,
                                         input logic ext, input logic mrd,
                                         input logic mwr, input logic dbs);
        return {st, pcw, pcs, irw, regw, rdst, srcb, aop, ext, mrd, mwr, dbs};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        for (int i = 0; i < 5; i++)
            if (fn == fn_tab[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic fn_known(input logic [5:0] fn);
        for (int i = 0; i < 5; i++)
            if (fn == fn_tab[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: the cycle-by-cycle control trace of one instruction.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic [2:0] aop;
        logic       is_r, wr, srcb, ext, taken;
        instr_q.delete();
        instr_q.push_back(pack(4'd0, 0, 2'b00, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0));
        case (op)
            6'h00, 6'h08, 6'h0d: begin
                is_r = (op == 6'h00);
                aop  = is_r ? alu_of(fn) : ((op == 6'h0d) ? 3'd3 : 3'd0);
                wr   = !is_r || fn_known(fn);
                srcb = !is_r;
                ext  = (op == 6'h08);
                instr_q.push_back(pack(4'd1, 0, 2'b00, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
                instr_q.push_back(pack(4'd2, 0, 2'b00, 0, 0, 0, srcb, aop, ext, 0, 0, 0));
                instr_q.push_back(pack(4'd3, 1, 2'b00, 0, wr, is_r, srcb, aop, ext, 0, 0, 0));
            end
            6'h23, 6'h2b: begin
                instr_q.push_back(pack(4'd1, 0, 2'b00, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
                instr_q.push_back(pack(4'd5, 0, 2'b00, 0, 0, 0, 1, 3'd0, 1, 0, 0, 0));
                if (op == 6'h23) begin
                    instr_q.push_back(pack(4'd6, 0, 2'b00, 0, 0, 0, 1, 3'd0, 1, 1, 0, 0));
                    instr_q.push_back(pack(4'd7, 1, 2'b00, 0, 1, 0, 0, 3'd0, 0, 0, 0, 1));
                end else begin
                    instr_q.push_back(pack(4'd6, 1, 2'b00, 0, 0, 0, 1, 3'd0, 1, 0, 1, 0));
                end
            end
            6'h04, 6'h05: begin
                taken = (op == 6'h04) ? z : !z;
                instr_q.push_back(pack(4'd1, 0, 2'b00, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
                instr_q.push_back(pack(4'd4, 1, taken ? 2'b01 : 2'b00, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0));
            end
            6'h02: instr_q.push_back(pack(4'd1, 1, 2'b10, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
            6'h3f: begin
                instr_q.push_back(pack(4'd1, 0, 2'b00, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
                repeat (20) instr_q.push_back(pack(4'd8, 0, 2'b00, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
            end
            default: instr_q.push_back(pack(4'd1, 1, 2'b00, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
        endcase
    endtask

    // Driver: hold Reset low for n cycles.
    task automatic reset_cycles(input int n);
        Reset = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(18'd0);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Driver: issue one instruction starting in IF; optionally abort it by
    // pulling Reset low partway through cycle abort_at.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int abort_at);
        int n;
        logic aborted;
        model_instr(op, fn, z);
        n = instr_q.size();
        aborted = 1'b0;
        if (abort_at >= 0 && abort_at < n) begin
            n = abort_at + 1;
            aborted = 1'b1;
        end
        Reset  = 1'b1;
        opcode = op;
        funct  = fn;
        for (int i = 0; i < n; i++) exp_q.push_back(instr_q[i]);
        for (int i = 0; i < n; i++) begin
            zero = (instr_q[i][17:14] == 4'd4) ? z : 1'($urandom_range(0, 1));
            if (aborted && i == n - 1) begin
                #6;
                Reset = 1'b0;
                #1;
                vectors++;
                if ({state, PCWre, IRWre, RegWre, mWR, mRD} !== 9'd0) begin
                    miscompares++;
                    $display("FAIL async_abort op=%h cyc=%0d: got state=%0d PCWre=%b IRWre=%b RegWre=%b mWR=%b mRD=%b, want state=0 enables=0",
                             op, i, state, PCWre, IRWre, RegWre, mWR, mRD);
                end
                @(posedge CLK);
                #1;
                exp_q.push_back(18'd0);
                @(posedge CLK);
                #1;
            end else begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        logic [17:0] e;
        if (mon_en) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL queue_underflow: got vec=%h with no expected entry", act_vec);
            end else begin
                e = exp_q.pop_front();
                if (act_vec !== e) begin
                    miscompares++;
                    $display("FAIL ctrl_vec t=%0t op=%h fn=%h: got %h (state=%0d) want %h (state=%0d)",
                             $time, opcode, funct, act_vec, act_vec[17:14], e, e[17:14]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int sel, ab;
        logic [5:0] op, fn;
        @(posedge CLK);
        #1;
        mon_en = 1'b1;
        reset_cycles(3);

        run_instr(6'h00, 6'b100000, 1'b0, -1);   // add
        run_instr(6'h23, 6'd0, 1'b0, -1);        // lw
        run_instr(6'h2b, 6'd0, 1'b0, -1);        // sw
        run_instr(6'h04, 6'd0, 1'b1, -1);        // beq taken
        run_instr(6'h04, 6'd0, 1'b0, -1);        // beq not taken
        run_instr(6'h05, 6'd0, 1'b0, -1);        // bne taken
        run_instr(6'h02, 6'd0, 1'b0, -1);        // j
        run_instr(6'h3f, 6'd0, 1'b0, -1);        // halt
        reset_cycles(2);
        run_instr(6'h2b, 6'd0, 1'b0, 3);         // sw aborted in MEM
        run_instr(6'h15, 6'd0, 1'b0, -1);        // undefined -> NOP
        run_instr(6'h08, 6'd0, 1'b0, -1);        // addi
        run_instr(6'h0d, 6'd0, 1'b0, -1);        // ori
        run_instr(6'h00, 6'b100010, 1'b0, -1);   // sub
        run_instr(6'h00, 6'b101010, 1'b0, -1);   // slt
        run_instr(6'h00, 6'b111000, 1'b0, -1);   // bad funct

        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 11);
            if (sel < 8) op = op_tab[sel];
            else if (sel < 11) op = 6'($urandom_range(0, 62));
            else op = 6'h3f;
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : fn_tab[$urandom_range(0, 4)];
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, fn, 1'($urandom_range(0, 1)), ab);
            if (op == 6'h3f) reset_cycles(1);
        end

        mon_en = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d leftover entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multi-cycle MIPS-subset CPU. It steps each instruction through IF/ID/EXE/MEM/WB states and drives every write enable and mux select of the datapath: PC register, instruction register, register file, ALU, data memory and writeback mux. It takes the opcode/funct fields from the instruction register and the ALU zero flag. It is the only block that asserts PC write-enable.

## Interface
- HALT_OP, 6'b111111, opcode that stops the machine.
- CLK  input  1  system clock; state updates on posedge.
- Reset  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26], stable from end of IF.
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag, valid during EXE.
- PCWre  output  1  PC write enable.
- PCSrc  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target.
- IRWre  output  1  instruction register write enable.
- RegWre  output  1  register file write enable.
- RegDst  output  1  1 = rd, 0 = rt.
- ALUSrcB  output  1  1 = extended immediate, 0 = rt data.
- ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- ExtSel  output  1  1 = sign-extend, 0 = zero-extend.
- mRD  output  1  data memory read.
- mWR  output  1  data memory write.
- DBDataSrc  output  1  writeback source: 1 = memory, 0 = ALU.
- state  output  4  current state code, for debug.

## Operation
- State codes:
  - IF=0000, ID=0001
  - EXE_AL=0010, WB_AL=0011
  - EXE_BR=0100
  - EXE_LS=0101, MEM=0110, WB_LD=0111
  - HALT=1000
- Supported opcodes: R-type 000000, addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, HALT_OP.
- R-type funct mapping: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- IF: IRWre=1, mRD=0; next state ID.
- ID transitions:
  - R-type, addi, ori -> EXE_AL.
  - beq, bne -> EXE_BR.
  - lw, sw -> EXE_LS.
  - j: PCWre=1, PCSrc=10 -> IF.
  - HALT_OP -> HALT.
  - Undefined opcode: PCWre=1, PCSrc=00 -> IF (executes as a NOP).
- EXE_AL -> WB_AL.
  - R-type: ALUSrcB=0, ALUOp from funct.
  - addi: ALUSrcB=1, ExtSel=1, ALUOp=000.
  - ori: ALUSrcB=1, ExtSel=0, ALUOp=011.
- WB_AL:
  - RegWre=1, DBDataSrc=0, PCWre=1, PCSrc=00; ALU controls held from EXE_AL; next IF.
  - RegDst=1 for R-type, 0 for addi/ori.
  - Undefined funct: RegWre=0, ALUOp=000, PC still advances.
- EXE_BR: ALUSrcB=0, ALUOp=001, PCWre=1; next IF.
  - PCSrc=01 if (beq && zero) or (bne && !zero), else 00.
- EXE_LS: ALUSrcB=1, ExtSel=1, ALUOp=000; next MEM.
- MEM (ALU controls held from EXE_LS):
  - lw: mRD=1 -> WB_LD.
  - sw: mWR=1, PCWre=1, PCSrc=00 -> IF.
- WB_LD: RegWre=1, RegDst=0, DBDataSrc=1, PCWre=1, PCSrc=00; next IF.
- HALT: all enables 0; stays in HALT until Reset.
- Any output not listed for a state is 0.

## Timing
- Outputs are combinational from state, opcode, funct and zero; there is no output register stage.
- State transitions occur on posedge CLK. Datapath registers (PC, IR) capture on the following negedge, while the controls are stable.
- Cycles per instruction:
  - R-type, addi, ori, sw: 4.
  - lw: 5.
  - beq, bne: 3.
  - j: 2.
  - Undefined opcode: 2.
- PCWre is asserted in exactly one state per instruction: its final state.
- Reset low: state=IF immediately, regardless of CLK.
  - While Reset is low, PCWre, IRWre, RegWre, mWR and mRD are forced to 0.
  - On release, the first posedge leaves IF for ID.
- Reset asserted mid-instruction (any state, including HALT) aborts the instruction. No write enable may glitch high during the abort.
- zero is sampled only in EXE_BR; its value in other states is ignored.

## Test plan
- Reset held low 3 cycles, then released:
  - During reset: state=0000, all enables 0.
  - First posedge after release: state=0001.
- add ($1 = $2 + $3) from IF: states 0000 -> 0001 -> 0010 -> 0011 -> 0000.
  - ALUOp=000 in EXE and WB.
  - RegWre=1, RegDst=1 and PCWre=1 in WB_AL only.
- lw then sw:
  - lw: 5 cycles; mRD=1 in MEM; DBDataSrc=1 and RegWre=1 in WB_LD.
  - sw: 4 cycles; mWR=1 and PCWre=1 in MEM; RegWre never asserted.
- beq with zero=1, then beq with zero=0, then bne with zero=0:
  - PCSrc=01, 00, 01 respectively.
  - Each takes 3 cycles with PCWre=1 in EXE_BR.
- j: PCWre=1, PCSrc=10 in ID; back to IF after 2 cycles. Opcode 111111: state 1000 held for 20 cycles with all enables 0.
- Reset pulled low mid-MEM of an sw: state goes to 0000 asynchronously and mWR drops to 0 in the same cycle. Undefined opcode 010101: NOP, with PCSrc=00 and PCWre=1 in ID.
